alu_share_arbiter: RTL

Time-shares one 64-bit ripple ALU between two requesters, such as the execute-stage issue and the branch-compare unit. It arbitrates requests, registers the winning operands and opcode onto the ALU inputs, and captures the ALU's Result/Overflow/Zero one cycle later. It returns that capture on a single tagged response channel. Only one operation is in flight at a time.

---
 rtl/alu_share_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Time-shares one external ALU between two requesters: arbitrate, register operands, capture flags, return a tagged response.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_share_arbiter #(
    parameter int WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    r0_valid,
    output logic                    r0_ready,
    input  logic signed [WIDTH-1:0] r0_a,
    input  logic signed [WIDTH-1:0] r0_b,
    input  logic [3:0]              r0_op,
    input  logic                    r1_valid,
    output logic                    r1_ready,
    input  logic signed [WIDTH-1:0] r1_a,
    input  logic signed [WIDTH-1:0] r1_b,
    input  logic [3:0]              r1_op,
    output logic signed [WIDTH-1:0] alu_a,
    output logic signed [WIDTH-1:0] alu_b,
    output logic [3:0]              alu_op,
    input  logic signed [WIDTH-1:0] alu_result,
    input  logic                    alu_overflow,
    input  logic                    alu_zero,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic                    resp_id,
    output logic signed [WIDTH-1:0] resp_result,
    output logic                    resp_overflow,
    output logic                    resp_zero,
    output logic                    resp_err
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                    state, state_nxt;
    logic                      gnt0, gnt1;
    logic                      take;
    logic signed [WIDTH-1:0]   sel_a, sel_b;
    logic [3:0]                sel_op;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: op_legal = 1'b1;
            default:                                              op_legal = 1'b0;
        endcase
    endfunction

`ifdef ALU_ARB_RR_EN
    // rr_ptr=1 favours requester 1 on a tie
    logic rr_ptr;

    always_comb begin
        gnt0 = r0_valid && (!r1_valid || !rr_ptr);
        gnt1 = r1_valid && (!r0_valid ||  rr_ptr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_ptr <= 1'b0;
        else if (take)
            rr_ptr <= gnt0;
    end
`else
    always_comb begin
        gnt0 = r0_valid;
        gnt1 = r1_valid && !r0_valid;
    end
`endif

    assign sel_a  = gnt1 ? r1_a  : r0_a;
    assign sel_b  = gnt1 ? r1_b  : r0_b;
    assign sel_op = gnt1 ? r1_op : r0_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Ready is gated by rst_n so it reads 0 while reset is held.
    always_comb begin
        state_nxt  = state;
        r0_ready   = 1'b0;
        r1_ready   = 1'b0;
        resp_valid = 1'b0;
        take       = 1'b0;
        case (state)
            IDLE: begin
                r0_ready = rst_n && gnt0;
                r1_ready = rst_n && gnt1;
                take     = rst_n && (gnt0 || gnt1);
                if (take)
                    state_nxt = op_legal(sel_op) ? EXEC : RESP;
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Illegal ops skip the ALU entirely, leaving its input registers untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a         <= '0;
            alu_b         <= '0;
            alu_op        <= 4'b0000;
            resp_id       <= 1'b0;
            resp_result   <= '0;
            resp_overflow <= 1'b0;
            resp_zero     <= 1'b0;
            resp_err      <= 1'b0;
        end else if (take) begin
            resp_id <= gnt1;
            if (op_legal(sel_op)) begin
                alu_a  <= sel_a;
                alu_b  <= sel_b;
                alu_op <= sel_op;
            end else begin
                resp_result   <= '0;
                resp_overflow <= 1'b0;
                resp_zero     <= 1'b0;
                resp_err      <= 1'b1;
            end
        end else if (state == EXEC) begin
            resp_result   <= alu_result;
            resp_overflow <= alu_overflow;
            resp_zero     <= alu_zero;
            resp_err      <= 1'b0;
        end
    end

endmodule
